key_note_tracker: RTL and testbench
===================================

KEY_NOTE_TRACKER -- requirements
Module: key_note_tracker

Interface
REQ-001 SHALL provide parameter N_OCT, default 5, number of selectable octaves (1..7).
REQ-002 SHALL provide parameter N_KEYS, default 13, keys per octave (1..15).
REQ-003 SHALL provide parameter NOTE_W, default 8, width of note code; N_OCT*N_KEYS SHALL fit in NOTE_W bits.
REQ-004 SHALL provide parameter OCT_INIT, default 1, octave loaded at reset (1..N_OCT).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 nota_entrada  in  4  current key code; 0 = no key; 1..N_KEYS valid; above N_KEYS treated as 0.
REQ-008 oct_up  in  1  one-cycle request to raise octave.
REQ-009 oct_dn  in  1  one-cycle request to lower octave.
REQ-010 nro_octava  out  3  current octave register.
REQ-011 nota_final  out  NOTE_W  code of held note; 0 when idle.
REQ-012 note_on  out  1  one-cycle pulse, new note started.
REQ-013 note_off  out  1  one-cycle pulse, held note ended.
REQ-014 active  out  1  high while a note is held.

Function
REQ-015 SHALL compute note code = (nro_octava-1)*N_KEYS + key, giving 1..N_OCT*N_KEYS; octave 1 key 1 = 1, octave 2 key 1 = N_KEYS+1.
REQ-016 SHALL implement two states: IDLE (no note) and HELD (note latched).
REQ-017 IDLE, valid key k sampled -> HELD; nota_final = code(k, current octave), note_on = 1, active = 1 after that edge (1-cycle latency).
REQ-018 IDLE, key 0 or invalid -> stay IDLE, no pulses.
REQ-019 HELD, same key sampled -> stay HELD, nota_final unchanged, no pulses.
REQ-020 HELD, key 0 or invalid sampled -> IDLE; note_off = 1, nota_final = 0, active = 0.
REQ-021 HELD, different valid key sampled -> stay HELD; note_off and note_on both = 1 in the same cycle; nota_final = new code.
REQ-022 note_on/note_off SHALL be high for exactly one cycle per event and low otherwise.
REQ-023 oct_up alone SHALL increment nro_octava, saturating at N_OCT.
REQ-024 oct_dn alone SHALL decrement nro_octava, saturating at 1.
REQ-025 oct_up and oct_dn together SHALL leave nro_octava unchanged.
REQ-026 octave change while HELD SHALL NOT alter nota_final or emit pulses; the new octave applies from the next note_on.
REQ-027 octave change and new key press in the same cycle: the note code SHALL use the octave value before the change.
REQ-028 all outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 rst = 1 at a rising edge SHALL force IDLE, nro_octava = OCT_INIT, nota_final = 0, note_on = 0, note_off = 0, active = 0.
REQ-030 reset while HELD SHALL NOT emit note_off; key still held after reset release SHALL produce note_on on the first edge after rst falls.
REQ-031 rst SHALL take priority over oct_up, oct_dn and key input in the same cycle.

Verification
REQ-032 Defaults, reset, key 5 held 3 cycles then 0 -> one note_on, nota_final = 5 for 3 cycles, one note_off, nota_final = 0.
REQ-033 Octave 3, key 1 then directly key 13 -> note_on with 27, then note_on + note_off same cycle with 39.
REQ-034 oct_up pulsed 6 times from octave 1 -> nro_octava 2,3,4,5,5,5; oct_dn 6 times -> 4,3,2,1,1,1; both together -> unchanged.
REQ-035 Hold key 2 at octave 1, pulse oct_up, keep holding -> nota_final stays 2, no pulses; release, press key 2 -> nota_final = 15.
REQ-036 Key 14 or 15 (N_KEYS = 13) in IDLE -> no pulse; while HELD -> note_off, nota_final = 0.
REQ-037 Assert rst while holding key 7 at octave 4 (code 46) -> outputs cleared, octave 1, no note_off; release rst with key 7 held -> note_on, nota_final = 7.

Source files
------------

// File: rtl/key_note_tracker.sv
// Keyboard note tracker: latches the currently pressed key as an octave-relative
// note code and emits one-cycle note_on / note_off pulses on every note change.
module key_note_tracker #(
    parameter int N_OCT    = 5,
    parameter int N_KEYS   = 13,
    parameter int NOTE_W   = 8,
    parameter int OCT_INIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        nota_entrada,
    input  logic              oct_up,
    input  logic              oct_dn,
    output logic [2:0]        nro_octava,
    output logic [NOTE_W-1:0] nota_final,
    output logic              note_on,
    output logic              note_off,
    output logic              active
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [2:0]        OCT_MIN    = 3'd1;
    localparam logic [2:0]        OCT_MAX    = 3'(N_OCT);
    localparam logic [2:0]        OCT_RESET  = 3'(OCT_INIT);
    localparam logic [3:0]        KEY_MAX    = 4'(N_KEYS);
    localparam logic [NOTE_W-1:0] KEYS_PER_O = NOTE_W'(N_KEYS);

    state_t            state;
    logic [3:0]        held_key;
    logic [3:0]        key;
    logic              key_valid;
    logic [NOTE_W-1:0] new_code;
    logic [2:0]        next_oct;

    // Codes above N_KEYS are folded to "no key" so the FSM only sees 0..N_KEYS.
    assign key_valid = (nota_entrada != 4'd0) && (nota_entrada <= KEY_MAX);
    assign key       = key_valid ? nota_entrada : 4'd0;

    // Uses the octave before any same-cycle oct_up/oct_dn takes effect.
    assign new_code = NOTE_W'(nro_octava - OCT_MIN) * KEYS_PER_O + NOTE_W'(key);

    always_comb begin
        next_oct = nro_octava;
        if (oct_up && !oct_dn && (nro_octava < OCT_MAX)) begin
            next_oct = nro_octava + 3'd1;
        end else if (oct_dn && !oct_up && (nro_octava > OCT_MIN)) begin
            next_oct = nro_octava - 3'd1;
        end
    end

    // NOTE: every output is a register updated with non-blocking assignments,
    // so there is no combinational path from any input to any output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            held_key   <= 4'd0;
            nro_octava <= OCT_RESET;
            nota_final <= '0;
            note_on    <= 1'b0;
            note_off   <= 1'b0;
            active     <= 1'b0;
        end else begin
            note_on    <= 1'b0;
            note_off   <= 1'b0;
            nro_octava <= next_oct;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state      <= HELD;
                        held_key   <= key;
                        nota_final <= new_code;
                        note_on    <= 1'b1;
                        active     <= 1'b1;
                    end
                end
                HELD: begin
                    if (!key_valid) begin
                        state      <= IDLE;
                        held_key   <= 4'd0;
                        nota_final <= '0;
                        note_off   <= 1'b1;
                        active     <= 1'b0;
                    end else if (key != held_key) begin
                        // Direct key change: end the old note and start the new one together.
                        held_key   <= key;
                        nota_final <= new_code;
                        note_on    <= 1'b1;
                        note_off   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_note_tracker.sv
// Self-checking bench for key_note_tracker: directed scenarios followed by random
// stimulus, all compared against a per-cycle behavioural model of held note and octave.
module tb_key_note_tracker;

    localparam int N_OCT    = 5;
    localparam int N_KEYS   = 13;
    localparam int NOTE_W   = 8;
    localparam int OCT_INIT = 1;

    logic              clk;
    logic              rst;
    logic [3:0]        nota_entrada;
    logic              oct_up;
    logic              oct_dn;
    logic [2:0]        nro_octava;
    logic [NOTE_W-1:0] nota_final;
    logic              note_on;
    logic              note_off;
    logic              active;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: octave number, key currently held (0 = none), outputs.
    int m_oct  = OCT_INIT;
    int m_held = 0;
    int m_note = 0;
    int m_on   = 0;
    int m_off  = 0;

    key_note_tracker #(
        .N_OCT   (N_OCT),
        .N_KEYS  (N_KEYS),
        .NOTE_W  (NOTE_W),
        .OCT_INIT(OCT_INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .nota_entrada(nota_entrada),
        .oct_up      (oct_up),
        .oct_dn      (oct_dn),
        .nro_octava  (nro_octava),
        .nota_final  (nota_final),
        .note_on     (note_on),
        .note_off    (note_off),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int k_raw, input bit up, input bit dn, input bit r);
        int k;
        if (r) begin
            m_oct  = OCT_INIT;
            m_held = 0;
            m_note = 0;
            m_on   = 0;
            m_off  = 0;
            return;
        end
        k     = (k_raw >= 1 && k_raw <= N_KEYS) ? k_raw : 0;
        m_on  = (k != 0 && k != m_held) ? 1 : 0;
        m_off = (m_held != 0 && k != m_held) ? 1 : 0;
        if (k != m_held) m_note = (k == 0) ? 0 : (m_oct - 1) * N_KEYS + k;
        m_held = k;
        if (up && !dn) m_oct = (m_oct < N_OCT) ? m_oct + 1 : N_OCT;
        else if (dn && !up) m_oct = (m_oct > 1) ? m_oct - 1 : 1;
    endtask

    // One clock cycle: drive inputs, let the edge happen, compare everything.
    task automatic step(input int k, input bit up, input bit dn, input bit r, input string tag);
        nota_entrada = 4'(k);
        oct_up       = up;
        oct_dn       = dn;
        rst          = r;
        @(posedge clk);
        model_update(k, up, dn, r);
        #1;
        check({tag, ".octave"},   int'(nro_octava), m_oct);
        check({tag, ".note"},     int'(nota_final), m_note);
        check({tag, ".note_on"},  int'(note_on),    m_on);
        check({tag, ".note_off"}, int'(note_off),   m_off);
        check({tag, ".active"},   int'(active),     (m_held != 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1, "reset");
        step(0, 0, 0, 1, "reset");
    endtask

    initial begin
        int k;
        bit up, dn, r;

        nota_entrada = 4'd0;
        oct_up       = 1'b0;
        oct_dn       = 1'b0;
        rst          = 1'b1;

        // Reset state, with absolute expectations as well as the model's.
        do_reset();
        check("rst.octave_abs", int'(nro_octava), 1);
        check("rst.note_abs",   int'(nota_final), 0);
        check("rst.active_abs", int'(active),     0);

        // Key 5 held three cycles, then released.
        step(5, 0, 0, 0, "k5a");
        check("k5.on_abs",   int'(note_on),    1);
        check("k5.note_abs", int'(nota_final), 5);
        step(5, 0, 0, 0, "k5b");
        step(5, 0, 0, 0, "k5c");
        check("k5.held_note_abs", int'(nota_final), 5);
        check("k5.held_on_abs",   int'(note_on),    0);
        step(0, 0, 0, 0, "k5off");
        check("k5.off_abs",      int'(note_off),   1);
        check("k5.off_note_abs", int'(nota_final), 0);
        step(0, 0, 0, 0, "k5idle");

        // Octave 3: key 1 then straight to key 13.
        step(0, 1, 0, 0, "o3up");
        step(0, 1, 0, 0, "o3up");
        step(1, 0, 0, 0, "o3k1");
        check("o3k1.note_abs", int'(nota_final), 27);
        step(13, 0, 0, 0, "o3k13");
        check("o3k13.note_abs", int'(nota_final), 39);
        check("o3k13.on_abs",   int'(note_on),    1);
        check("o3k13.off_abs",  int'(note_off),   1);
        step(0, 0, 0, 0, "o3rel");

        // Octave saturation both ways, and simultaneous requests.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, "sat_up");
            check("sat_up.abs", int'(nro_octava), (i + 2 > 5) ? 5 : i + 2);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, "sat_dn");
            check("sat_dn.abs", int'(nro_octava), (4 - i < 1) ? 1 : 4 - i);
        end
        step(0, 0, 1, 0, "to_2_prep");
        step(0, 1, 0, 0, "to_2");
        step(0, 1, 1, 0, "both");
        check("both.abs", int'(nro_octava), 2);

        // Octave change while a note is held does not touch the note.
        do_reset();
        step(2, 0, 0, 0, "hold2");
        step(2, 1, 0, 0, "hold2up");
        step(2, 0, 0, 0, "hold2b");
        check("hold2.note_abs", int'(nota_final), 2);
        step(0, 0, 0, 0, "hold2rel");
        step(2, 0, 0, 0, "hold2new");
        check("hold2new.note_abs", int'(nota_final), 15);

        // Out-of-range keys behave as no key.
        do_reset();
        step(14, 0, 0, 0, "k14idle");
        step(15, 0, 0, 0, "k15idle");
        check("k15idle.on_abs", int'(note_on), 0);
        step(3, 0, 0, 0, "k3");
        step(14, 0, 0, 0, "k14held");
        check("k14held.off_abs",  int'(note_off),   1);
        check("k14held.note_abs", int'(nota_final), 0);

        // Key press with same-cycle octave change uses the old octave.
        step(4, 1, 0, 0, "press_up");
        check("press_up.note_abs", int'(nota_final), 4);
        step(0, 0, 0, 0, "press_up_rel");

        // Reset while holding key 7 at octave 4.
        do_reset();
        step(0, 1, 0, 0, "o4");
        step(0, 1, 0, 0, "o4");
        step(0, 1, 0, 0, "o4");
        step(7, 0, 0, 0, "o4k7");
        check("o4k7.note_abs", int'(nota_final), 46);
        step(7, 1, 0, 1, "rst_held");
        check("rst_held.off_abs",  int'(note_off),   0);
        check("rst_held.oct_abs",  int'(nro_octava), 1);
        check("rst_held.note_abs", int'(nota_final), 0);
        step(7, 0, 0, 0, "after_rst");
        check("after_rst.on_abs",   int'(note_on),    1);
        check("after_rst.note_abs", int'(nota_final), 7);

        // Random traffic: keys tend to persist so HELD periods are long.
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, 15));
            up = ($urandom_range(0, 9) == 0);
            dn = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 199) == 0);
            step(k, up, dn, r, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
